adc_acq_sequencer: RTL and testbench

//  Acquisition controller for the 100MS/s ADC datapath. Sequences each shot through pre-trigger

---
 rtl/adc_acq_pkg.sv | 22 ++
 rtl/adc_acq_counter.sv | 47 ++++
 rtl/adc_acq_sequencer.sv | 139 +++++++++++++
 tb/tb_adc_acq_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_acq_pkg.sv
// Shared types and constants for the ADC acquisition sequencer.
// The state encodings are exported so CSR status decode can use the same values.
package adc_acq_pkg;

  localparam int c_SAMPLE_W = 32;
  localparam int c_SHOT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE_TRIG  = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST_TRIG = 3'd3,
    ST_DECR_SHOT = 3'd4
  } t_acq_state;

  localparam logic [2:0] c_ST_IDLE      = 3'd0;
  localparam logic [2:0] c_ST_PRE_TRIG  = 3'd1;
  localparam logic [2:0] c_ST_WAIT_TRIG = 3'd2;
  localparam logic [2:0] c_ST_POST_TRIG = 3'd3;
  localparam logic [2:0] c_ST_DECR_SHOT = 3'd4;

endpackage

// File: rtl/adc_acq_counter.sv
// Loadable up-counter with terminal compare against a programmed target.
// done_o fires in the cycle of the final counted increment, or at once for a zero target.
module adc_acq_counter
  import adc_acq_pkg::*;
#(
  parameter int g_W = c_SAMPLE_W
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           load_i,
  input  logic [g_W-1:0] target_i,
  input  logic           clr_i,
  input  logic           inc_i,
  output logic           done_o
);

  localparam logic [g_W-1:0] c_ONE = g_W'(1);

  logic [g_W-1:0] cnt_q, cnt_d;
  logic [g_W-1:0] target_q, target_d;

  always_comb begin
    cnt_d    = cnt_q;
    target_d = target_q;
    if (load_i) begin
      target_d = target_i;
      cnt_d    = '0;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + c_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  assign done_o = (target_q == '0) | (inc_i & ((cnt_q + c_ONE) == target_q));

endmodule

// File: rtl/adc_acq_sequencer.sv
// Acquisition sequencer: per shot, pre-trigger fill, trigger wait and post-trigger capture,
// repeated for the configured shot count while driving storage write enable/address.
module adc_acq_sequencer
  import adc_acq_pkg::*;
#(
  parameter int g_SAMPLE_W = c_SAMPLE_W,
  parameter int g_SHOT_W   = c_SHOT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [g_SAMPLE_W-1:0] pre_samples_i,
  input  logic [g_SAMPLE_W-1:0] post_samples_i,
  input  logic [g_SHOT_W-1:0]   nshots_i,
  input  logic                  trig_i,
  input  logic                  sample_valid_i,
  output logic                  wr_en_o,
  output logic [g_SAMPLE_W-1:0] wr_addr_o,
  output logic [g_SAMPLE_W-1:0] trig_addr_o,
  output logic [g_SHOT_W-1:0]   shots_left_o,
  output logic [2:0]            state_o,
  output logic                  acq_end_o,
  output logic                  cfg_err_o
);

  t_acq_state            state_q, state_d;
  logic [g_SAMPLE_W-1:0] wr_addr_q, wr_addr_d;
  logic [g_SAMPLE_W-1:0] trig_addr_q, trig_addr_d;
  logic [g_SHOT_W-1:0]   shots_q, shots_d;
  logic                  cfg_err_q, cfg_err_d;

  logic cfg_load, pre_clr, post_clr, acq_end;
  logic pre_done, post_done, wr_en;

  assign wr_en = sample_valid_i & ((state_q == ST_PRE_TRIG) | (state_q == ST_WAIT_TRIG) |
                                   (state_q == ST_POST_TRIG));

  adc_acq_counter #(.g_W(g_SAMPLE_W)) u_pre_cnt (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .load_i   (cfg_load),
    .target_i (pre_samples_i),
    .clr_i    (pre_clr),
    .inc_i    (sample_valid_i & (state_q == ST_PRE_TRIG)),
    .done_o   (pre_done)
  );

  adc_acq_counter #(.g_W(g_SAMPLE_W)) u_post_cnt (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .load_i   (cfg_load),
    .target_i (post_samples_i),
    .clr_i    (post_clr),
    .inc_i    (sample_valid_i & (state_q == ST_POST_TRIG)),
    .done_o   (post_done)
  );

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q + {{(g_SAMPLE_W-1){1'b0}}, wr_en};
    trig_addr_d = trig_addr_q;
    shots_d     = shots_q;
    cfg_err_d   = cfg_err_q;
    cfg_load    = 1'b0;
    pre_clr     = 1'b0;
    post_clr    = 1'b0;
    acq_end     = 1'b0;
    // stop outranks everything; in IDLE it also suppresses a coincident start
    if (stop_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if ((nshots_i != '0) && (post_samples_i != '0)) begin
              cfg_load  = 1'b1;
              shots_d   = nshots_i;
              wr_addr_d = '0;
              cfg_err_d = 1'b0;
              state_d   = ST_PRE_TRIG;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        ST_PRE_TRIG: begin
          if (pre_done) state_d = ST_WAIT_TRIG;
        end
        ST_WAIT_TRIG: begin
          if (trig_i) begin
            trig_addr_d = wr_addr_q;
            post_clr    = 1'b1;
            state_d     = ST_POST_TRIG;
          end
        end
        ST_POST_TRIG: begin
          if (post_done) state_d = ST_DECR_SHOT;
        end
        ST_DECR_SHOT: begin
          shots_d = shots_q - g_SHOT_W'(1);
          if (shots_q == g_SHOT_W'(1)) begin
            acq_end = 1'b1;
            state_d = ST_IDLE;
          end else begin
            pre_clr = 1'b1;
            state_d = ST_PRE_TRIG;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      trig_addr_q <= '0;
      shots_q     <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      trig_addr_q <= trig_addr_d;
      shots_q     <= shots_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign wr_en_o      = wr_en;
  assign wr_addr_o    = wr_addr_q;
  assign trig_addr_o  = trig_addr_q;
  assign shots_left_o = shots_q;
  assign state_o      = state_q;
  assign acq_end_o    = acq_end;
  assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Directed bench for adc_acq_sequencer with hand-computed expected values.
module tb_adc_acq_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, trig, sample_valid;
  logic [31:0] pre_samples, post_samples;
  logic [15:0] nshots;
  logic        wr_en, acq_end, cfg_err;
  logic [31:0] wr_addr, trig_addr;
  logic [15:0] shots_left;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_mis = 0;

  adc_acq_sequencer dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .stop_i         (stop),
    .pre_samples_i  (pre_samples),
    .post_samples_i (post_samples),
    .nshots_i       (nshots),
    .trig_i         (trig),
    .sample_valid_i (sample_valid),
    .wr_en_o        (wr_en),
    .wr_addr_o      (wr_addr),
    .trig_addr_o    (trig_addr),
    .shots_left_o   (shots_left),
    .state_o        (state),
    .acq_end_o      (acq_end),
    .cfg_err_o      (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] pre, input logic [31:0] post, input logic [15:0] n);
    pre_samples  = pre;
    post_samples = post;
    nshots       = n;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_post, guard, n_decr, acq_seen;
    logic [31:0] exp_trig [3];
    exp_trig = '{32'd4, 32'd16, 32'd28};

    rst_n = 1'b0; start = 0; stop = 0; trig = 0; sample_valid = 1'b1;
    pre_samples = 0; post_samples = 0; nshots = 0;
    repeat (3) tick();
    check("rst_state", state, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_trig_addr", trig_addr, 0);
    check("rst_shots", shots_left, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_acq_end", acq_end, 0);
    check("rst_wr_en", wr_en, 0);
    rst_n = 1'b1;
    tick();
    check("idle_wr_en", wr_en, 0);

    // ---- single shot: pre=0, post=16, continuous valid, trigger ~1us after start
    do_start(32'd0, 32'd16, 16'd1);
    check("t1_pre_state", state, 1);
    check("t1_pre_wr_en", wr_en, 1);
    tick();
    check("t1_wait_state", state, 2);
    check("t1_wait_addr", wr_addr, 1);
    repeat (98) tick();
    check("t1_wait_hold", state, 2);
    check("t1_wait_addr99", wr_addr, 99);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("t1_post_state", state, 3);
    check("t1_trig_addr", trig_addr, 99);
    n_post = 0; guard = 0;
    while (state == 3'd3 && guard < 40) begin
      if (wr_en) n_post++;
      tick();
      guard++;
    end
    check("t1_post_count", n_post, 16);
    check("t1_decr_state", state, 4);
    check("t1_acq_end", acq_end, 1);
    check("t1_wr_addr", wr_addr, 116);
    tick();
    check("t1_idle", state, 0);
    check("t1_acq_end_gone", acq_end, 0);
    check("t1_shots_left", shots_left, 0);
    check("t1_no_wr", wr_en, 0);

    // ---- three shots: pre=4, post=8; samples only while filling/capturing
    sample_valid = 1'b0;
    do_start(32'd4, 32'd8, 16'd3);
    check("t2_shots_init", shots_left, 3);
    n_decr = 0; acq_seen = 0;
    for (int s = 0; s < 3; s++) begin
      sample_valid = 1'b1;
      if (s == 1) begin
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("t2_pre_trig_ignored", state, 1);
        check("t2_pre_trig_addr", trig_addr, 4);
      end
      guard = 0;
      while (state == 3'd1 && guard < 20) begin tick(); guard++; end
      sample_valid = 1'b0;
      check("t2_wait_state", state, 2);
      repeat (100) tick();
      check("t2_wait_hold", state, 2);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      check("t2_trig_addr", trig_addr, exp_trig[s]);
      check("t2_shots_left", shots_left, 3 - s);
      sample_valid = 1'b1;
      if (s == 1) begin
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("t2_post_trig_ignored", state, 3);
        check("t2_post_trig_addr", trig_addr, 16);
      end
      guard = 0;
      while (state == 3'd3 && guard < 20) begin tick(); guard++; end
      sample_valid = 1'b0;
      if (state == 3'd4) n_decr++;
      if (acq_end) acq_seen++;
      check("t2_decr_wr_en", wr_en, 0);
      tick();
    end
    check("t2_decr_visits", n_decr, 3);
    check("t2_acq_end_once", acq_seen, 1);
    check("t2_idle", state, 0);
    check("t2_shots_zero", shots_left, 0);
    check("t2_final_addr", wr_addr, 36);

    // ---- bad configs, then recovery; toggling valid with pre=2, post=3
    do_start(32'd2, 32'd5, 16'd0);
    check("t3_err_nshots", cfg_err, 1);
    check("t3_err_state", state, 0);
    do_start(32'd2, 32'd0, 16'd2);
    check("t3_err_post", cfg_err, 1);
    check("t3_err_state2", state, 0);
    do_start(32'd2, 32'd3, 16'd1);
    check("t3_err_cleared", cfg_err, 0);
    check("t3_pre_state", state, 1);
    check("t3_addr_clr", wr_addr, 0);
    pre_samples = 32'd50; post_samples = 32'd50; nshots = 16'd9;
    sample_valid = 1'b0; tick();
    sample_valid = 1'b1; tick();
    sample_valid = 1'b0; tick();
    check("t3_pre_one_counted", state, 1);
    sample_valid = 1'b1; tick();
    sample_valid = 1'b0;
    check("t3_wait", state, 2);
    check("t3_wait_addr", wr_addr, 2);
    sample_valid = 1'b1; trig = 1'b1; tick();
    sample_valid = 1'b0; trig = 1'b0;
    check("t3_post", state, 3);
    check("t3_trig_addr", trig_addr, 2);
    check("t3_trig_sample_written", wr_addr, 3);
    for (int i = 0; i < 5; i++) begin
      sample_valid = (i % 2 == 1);
      tick();
    end
    check("t3_post_two_counted", state, 3);
    sample_valid = 1'b1; tick();
    sample_valid = 1'b0;
    check("t3_decr", state, 4);
    check("t3_acq_end", acq_end, 1);
    check("t3_latched_shots", shots_left, 1);
    check("t3_end_addr", wr_addr, 6);
    tick();
    check("t3_idle", state, 0);

    // ---- stop during post capture of shot 2 of 3, then restart
    sample_valid = 1'b1;
    do_start(32'd1, 32'd4, 16'd3);
    tick();
    check("t4_wait", state, 2);
    trig = 1'b1; tick(); trig = 1'b0;
    check("t4_trig1", trig_addr, 1);
    repeat (4) tick();
    check("t4_decr", state, 4);
    check("t4_decr_no_end", acq_end, 0);
    tick();
    check("t4_shot2_pre", state, 1);
    check("t4_shots2", shots_left, 2);
    tick();
    trig = 1'b1; tick(); trig = 1'b0;
    check("t4_trig2", trig_addr, 7);
    tick();
    stop = 1'b1;
    check("t4_stop_cycle_wr", wr_en, 1);
    tick();
    stop = 1'b0;
    check("t4_stop_idle", state, 0);
    check("t4_stop_wr_en", wr_en, 0);
    check("t4_stop_no_end", acq_end, 0);
    check("t4_stop_shots", shots_left, 2);
    check("t4_stop_trig", trig_addr, 7);
    check("t4_stop_addr", wr_addr, 10);
    acq_seen = 0;
    repeat (5) begin tick(); if (acq_end) acq_seen++; end
    check("t4_stop_quiet", acq_seen, 0);
    do_start(32'd0, 32'd2, 16'd1);
    check("t4_restart_state", state, 1);
    check("t4_restart_addr", wr_addr, 0);
    check("t4_restart_shots", shots_left, 1);

    // ---- async reset in the middle of trigger wait
    tick();
    check("t5_wait", state, 2);
    tick();
    check("t5_addr_nonzero", wr_addr, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_state", state, 0);
    check("t5_rst_addr", wr_addr, 0);
    check("t5_rst_shots", shots_left, 0);
    check("t5_rst_wr_en", wr_en, 0);
    check("t5_rst_acq_end", acq_end, 0);
    check("t5_rst_cfg_err", cfg_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_post_rst_idle", state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
